// File: rtl/value_register_controller_pkg.sv
// -----------------------------------------------------------------------------
// value_ctrl_pkg
// Shared types for the value register controller:
//   state_e   - controller FSM states
//   op_e      - operation selected from a captured button vector
//   BTN_*     - bit positions inside the synchronized vector {init, load, inc, dec}
//   prio_sel  - fixed-priority decode init > load > inc > dec
// -----------------------------------------------------------------------------
package value_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_APPLY,
        ST_WAIT_RELEASE
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_INIT,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } op_e;

    localparam int BTN_N    = 4;
    localparam int BTN_INIT = 3;
    localparam int BTN_LOAD = 2;
    localparam int BTN_INC  = 1;
    localparam int BTN_DEC  = 0;

    function automatic op_e prio_sel(input logic [BTN_N-1:0] btn);
        if (btn[BTN_INIT]) return OP_INIT;
        if (btn[BTN_LOAD]) return OP_LOAD;
        if (btn[BTN_INC])  return OP_INC;
        if (btn[BTN_DEC])  return OP_DEC;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/value_register_controller_btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
// N-wide two-flop synchronizer for asynchronous button inputs.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset (both flop ranks clear to 0)
//   raw    - asynchronous inputs
//   synced - inputs after two flops in the clk domain
// -----------------------------------------------------------------------------
module btn_sync #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] raw,
    output logic [N-1:0] synced
);

    logic [N-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/value_register_controller.sv
// -----------------------------------------------------------------------------
// value_register_controller
// Drives a WIDTH-bit value register from four front-panel buttons. Buttons are
// synchronized, debounced, priority-arbitrated (init > load > inc > dec) and
// each accepted press performs exactly one operation; the controller then waits
// for a debounced full release before accepting another press.
//
// Build option: define VALUE_CTRL_SATURATE_EN to make inc/dec saturate at
// all-ones/zero instead of wrapping modulo 2^WIDTH.
//
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   init_btn   - async button, value <= 0
//   load_btn   - async button, value <= load_value
//   inc_btn    - async button, value <= value + 1
//   dec_btn    - async button, value <= value - 1
//   load_value - load operand, sampled during the single APPLY cycle
//   value      - registered current value
//   busy       - high whenever the FSM is not idle
//   op_done    - one-cycle pulse, first cycle the new value is visible
// -----------------------------------------------------------------------------
module value_register_controller
    import value_ctrl_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_btn,
    input  logic             load_btn,
    input  logic             inc_btn,
    input  logic             dec_btn,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             op_done
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] VAL_ONE  = WIDTH'(1);

    state_e           state;
    state_e           state_next;
    logic [BTN_N-1:0] btn_s;
    logic [BTN_N-1:0] cap;
    logic [BTN_N-1:0] cap_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    op_e              op;
    logic [WIDTH-1:0] value_next;
    logic             apply;

    function automatic logic [WIDTH-1:0] inc_val(input logic [WIDTH-1:0] v);
`ifdef VALUE_CTRL_SATURATE_EN
        return (&v) ? v : v + VAL_ONE;
`else
        return v + VAL_ONE;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] dec_val(input logic [WIDTH-1:0] v);
`ifdef VALUE_CTRL_SATURATE_EN
        return (v == '0) ? v : v - VAL_ONE;
`else
        return v - VAL_ONE;
`endif
    endfunction

    btn_sync #(.N(BTN_N)) u_btn_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    ({init_btn, load_btn, inc_btn, dec_btn}),
        .synced (btn_s)
    );

    // State, captured vector and debounce counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cap   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cap   <= cap_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cap_next   = cap;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (btn_s != '0) begin
                    cap_next   = btn_s;
                    cnt_next   = '0;
                    state_next = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (btn_s == '0) begin
                    state_next = ST_IDLE;
                end else if (btn_s != cap) begin
                    // A different combination restarts the stability window.
                    cap_next = btn_s;
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_APPLY;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_APPLY: begin
                cnt_next   = '0;
                state_next = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                // Any held button, even a newly added one, only delays the
                // return to idle; it never starts another operation.
                if (btn_s != '0) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        op         = OP_NONE;
        apply      = 1'b0;
        value_next = value;
        if (state == ST_APPLY) begin
            apply = 1'b1;
            op    = prio_sel(cap);
            case (op)
                OP_INIT: value_next = '0;
                OP_LOAD: value_next = load_value;
                OP_INC:  value_next = inc_val(value);
                OP_DEC:  value_next = dec_val(value);
                default: value_next = value;
            endcase
        end
    end

    // Value and completion pulse update together at the APPLY exit edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value   <= '0;
            op_done <= 1'b0;
        end else begin
            value   <= value_next;
            op_done <= apply;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_value_register_controller.sv
// -----------------------------------------------------------------------------
// tb_value_register_controller
// Self-checking bench for value_register_controller (WIDTH=4, DEBOUNCE_CYCLES=4).
// Honours VALUE_CTRL_SATURATE_EN for the expected inc/dec boundary results.
// -----------------------------------------------------------------------------
module tb_value_register_controller;

    localparam int W  = 4;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         init_btn = 1'b0;
    logic         load_btn = 1'b0;
    logic         inc_btn = 1'b0;
    logic         dec_btn = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] value;
    logic         busy;
    logic         op_done;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    value_register_controller #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_btn   (init_btn),
        .load_btn   (load_btn),
        .inc_btn    (inc_btn),
        .dec_btn    (dec_btn),
        .load_value (load_value),
        .value      (value),
        .busy       (busy),
        .op_done    (op_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (op_done === 1'b1) pulses++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0] vec;      // {init, load, inc, dec}
        logic [3:0] lv;
        int         hold;
        logic [3:0] exp_val;
        int         exp_pulses;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: which single operation a press vector performs, and its result.
    function automatic logic [3:0] model(input logic [3:0] v, input logic [3:0] b, input logic [3:0] lv);
        int r;
        r = int'(v);
        if (b[3])      r = 0;
        else if (b[2]) r = int'(lv);
        else if (b[1]) begin
`ifdef VALUE_CTRL_SATURATE_EN
            r = (r == 15) ? 15 : r + 1;
`else
            r = (r + 1) % 16;
`endif
        end else if (b[0]) begin
`ifdef VALUE_CTRL_SATURATE_EN
            r = (r == 0) ? 0 : r - 1;
`else
            r = (r + 15) % 16;
`endif
        end
        return 4'(r);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        {init_btn, load_btn, inc_btn, dec_btn} = 4'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic episode(input logic [3:0] vec, input logic [3:0] lv, input int hold, input int gap);
        @(negedge clk);
        {init_btn, load_btn, inc_btn, dec_btn} = vec;
        load_value = lv;
        repeat (hold) @(negedge clk);
        {init_btn, load_btn, inc_btn, dec_btn} = 4'b0;
        repeat (gap) @(negedge clk);
        #1;
    endtask

    initial begin
        int p0;
        logic [3:0] mval;
        logic [3:0] vec;
        logic [3:0] lv;
        int hold;
        bit glitch;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("reset_value", 32'(value), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_op_done", 32'(op_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- exact latency of a clean inc press ----------------
        p0 = pulses;
        inc_btn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat_value_e%0d", k), 32'(value), (k >= 7) ? 32'd1 : 32'd0);
            check($sformatf("lat_op_done_e%0d", k), 32'(op_done), (k == 7) ? 32'd1 : 32'd0);
            check($sformatf("lat_busy_e%0d", k), 32'(busy), (k >= 2 && k < 25) ? 32'd1 : 32'd0);
            if (k == 19) inc_btn = 1'b0;
        end
        #1;
        check("lat_pulse_count", 32'(pulses - p0), 32'd1);

        // ---------------- table-driven vectors ----------------
        do_reset();
        tbl[0]  = '{4'b0010, 4'd0,  8,   4'd1,  1};
        tbl[1]  = '{4'b0100, 4'd15, 8,   4'd15, 1};
`ifdef VALUE_CTRL_SATURATE_EN
        tbl[2]  = '{4'b0010, 4'd0,  8,   4'd15, 1};
`else
        tbl[2]  = '{4'b0010, 4'd0,  8,   4'd0,  1};
`endif
        tbl[3]  = '{4'b1000, 4'd0,  8,   4'd0,  1};
`ifdef VALUE_CTRL_SATURATE_EN
        tbl[4]  = '{4'b0001, 4'd0,  8,   4'd0,  1};
`else
        tbl[4]  = '{4'b0001, 4'd0,  8,   4'd15, 1};
`endif
        tbl[5]  = '{4'b0110, 4'd9,  8,   4'd9,  1};
        tbl[6]  = '{4'b0001, 4'd0,  2,   4'd9,  0};
        tbl[7]  = '{4'b1111, 4'd3,  8,   4'd0,  1};
        tbl[8]  = '{4'b0101, 4'd6,  8,   4'd6,  1};
        tbl[9]  = '{4'b1000, 4'd0,  100, 4'd0,  1};
        tbl[10] = '{4'b0011, 4'd0,  8,   4'd1,  1};
        tbl[11] = '{4'b0001, 4'd0,  DC+1, 4'd0, 1};
        tbl[12] = '{4'b0010, 4'd0,  DC,  4'd0,  0};
        tbl[13] = '{4'b0100, 4'd12, DC+1, 4'd12, 1};

        for (int i = 0; i < 14; i++) begin
            p0 = pulses;
            episode(tbl[i].vec, tbl[i].lv, tbl[i].hold, 10);
            check($sformatf("tbl%0d_value", i), 32'(value), 32'(tbl[i].exp_val));
            check($sformatf("tbl%0d_pulses", i), 32'(pulses - p0), 32'(tbl[i].exp_pulses));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'd0);
        end

        // ---------------- randomized presses and glitches ----------------
        mval = tbl[13].exp_val;
        for (int i = 0; i < 40; i++) begin
            vec    = 4'($urandom_range(1, 15));
            lv     = 4'($urandom_range(0, 15));
            glitch = ($urandom_range(0, 3) == 0);
            hold   = glitch ? int'($urandom_range(1, DC)) : int'($urandom_range(DC + 1, 12));
            p0 = pulses;
            episode(vec, lv, hold, 10);
            if (!glitch) mval = model(mval, vec, lv);
            check($sformatf("rnd%0d_value", i), 32'(value), 32'(mval));
            check($sformatf("rnd%0d_pulses", i), 32'(pulses - p0), glitch ? 32'd0 : 32'd1);
            check($sformatf("rnd%0d_busy", i), 32'(busy), 32'd0);
        end

        // ---------------- reset while waiting for release ----------------
        p0 = pulses;
        @(negedge clk);
        load_value = 4'd5;
        load_btn   = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_pre_value", 32'(value), 32'd5);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_value", 32'(value), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_op_done", 32'(op_done), 32'd0);
        load_value = 4'd7;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_repress_value_e%0d", k), 32'(value), (k >= 7) ? 32'd7 : 32'd0);
        end
        @(negedge clk);
        load_btn = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("rst_repress_busy", 32'(busy), 32'd0);
        check("rst_repress_pulses", 32'(pulses - p0), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
